// File: rtl/mem_access_unit_pkg.sv
// Shared types and default sizes for the data-memory access unit.
// The data memory derives its depth from MEM_WORDS_DEF.
package mem_access_unit_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int MEM_WORDS_DEF  = 256;

    typedef enum logic [2:0] {
        sIdle    = 3'd0,
        sSetup   = 3'd1,
        sStrobe  = 3'd2,
        sRelease = 3'd3,
        sResp    = 3'd4
    } mauStateT;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle and data-memory bus bundle.
// master = side that initiates; slave = side that serves.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mem_bus_if
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one request at a time, setup/strobe/release
// sequencing of registered memory strobes, then a held response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MEM_WORDS  = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  req,
    mem_bus_if.master         mem
);

    mauStateT              stateQ;
    logic                  wrLat;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic                  errQ;
    logic                  rdQ;
    logic                  wrQ;
    logic                  outOfRange;

    // Widened compare so no address can wrap into range.
    assign outOfRange = 64'(req.req_addr) >= 64'(MEM_WORDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= sIdle;
            wrLat  <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
            rdQ    <= 1'b0;
            wrQ    <= 1'b0;
        end else begin
            unique case (stateQ)
                sIdle: begin
                    if (req.req_valid) begin
                        wrLat  <= req.req_write;
                        rdataQ <= '0;
                        if (outOfRange) begin
                            errQ   <= 1'b1;
                            stateQ <= sResp;
                        end else begin
                            errQ   <= 1'b0;
                            addrQ  <= req.req_addr;
                            wdataQ <= req.req_wdata;
                            stateQ <= sSetup;
                        end
                    end
                end
                sSetup: begin
                    rdQ    <= ~wrLat;
                    wrQ    <= wrLat;
                    stateQ <= sStrobe;
                end
                sStrobe: begin
                    rdQ <= 1'b0;
                    wrQ <= 1'b0;
                    if (!wrLat) rdataQ <= mem.mem_read_data;
                    stateQ <= sRelease;
                end
                sRelease: stateQ <= sResp;
                sResp: begin
                    if (req.resp_ready) stateQ <= sIdle;
                end
                default: stateQ <= sIdle;
            endcase
        end
    end

    assign req.req_ready      = (stateQ == sIdle);
    assign req.resp_valid     = (stateQ == sResp);
    assign req.resp_rdata     = rdataQ;
    assign req.resp_err       = errQ;
    assign mem.mem_read       = rdQ;
    assign mem.mem_write      = wrQ;
    assign mem.mem_address    = addrQ;
    assign mem.mem_write_data = wdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed memory.
// Checks latency, strobe windows, range errors, backpressure and reset.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   overlap = 0;
    int   rdCycles = 0;
    int   wrCycles = 0;

    logic [DATA_WIDTH_DEF-1:0] memArr [MEM_WORDS_DEF];

    mem_access_unit_if #(.DATA_WIDTH(DATA_WIDTH_DEF), .ADDR_WIDTH(ADDR_WIDTH_DEF)) rq ();
    mem_bus_if #(.DATA_WIDTH(DATA_WIDTH_DEF), .ADDR_WIDTH(ADDR_WIDTH_DEF)) mb ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .req (rq.slave),
        .mem (mb.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mb.mem_write) memArr[mb.mem_address[7:0]] <= mb.mem_write_data;
    end

    assign mb.mem_read_data = memArr[mb.mem_address[7:0]];

    always @(negedge clk) begin
        if (mb.mem_read && mb.mem_write) overlap++;
        if (mb.mem_read) rdCycles++;
        if (mb.mem_write) wrCycles++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr,
                         input logic [15:0] data);
        rq.req_valid = 1'b1;
        rq.req_write = wr;
        rq.req_addr  = addr;
        rq.req_wdata = data;
        tick();
        rq.req_valid = 1'b0;
    endtask

    initial begin
        int acc [3];
        int bad;
        int n;
        int rdBefore;
        int wrBefore;
        logic [15:0] addrs [3];
        logic [15:0] datas [3];

        for (int i = 0; i < MEM_WORDS_DEF; i++) memArr[i] = '0;
        rq.req_valid = 1'b0;
        rq.req_write = 1'b0;
        rq.req_addr = '0;
        rq.req_wdata = '0;
        rq.resp_ready = 1'b0;

        #12;
        chk("rst_req_ready", 32'(rq.req_ready), 1);
        chk("rst_resp_valid", 32'(rq.resp_valid), 0);
        chk("rst_resp_err", 32'(rq.resp_err), 0);
        chk("rst_resp_rdata", 32'(rq.resp_rdata), 0);
        chk("rst_mem_strobes", {30'd0, mb.mem_read, mb.mem_write}, 0);
        chk("rst_mem_address", 32'(mb.mem_address), 0);
        chk("rst_mem_wdata", 32'(mb.mem_write_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Store 0xBEEF to 5.
        issue(1'b1, 16'h0005, 16'hBEEF);
        chk("st_c1_addr", 32'(mb.mem_address), 32'h5);
        chk("st_c1_strobes", {30'd0, mb.mem_read, mb.mem_write}, 0);
        chk("st_c1_ready", 32'(rq.req_ready), 0);
        tick();
        chk("st_c2_strobes", {30'd0, mb.mem_read, mb.mem_write}, 1);
        chk("st_c2_addr", 32'(mb.mem_address), 32'h5);
        chk("st_c2_wdata", 32'(mb.mem_write_data), 32'hBEEF);
        tick();
        chk("st_c3_strobes", {30'd0, mb.mem_read, mb.mem_write}, 0);
        chk("st_c3_addr", 32'(mb.mem_address), 32'h5);
        chk("st_c3_valid", 32'(rq.resp_valid), 0);
        tick();
        chk("st_c4_valid", 32'(rq.resp_valid), 1);
        chk("st_c4_err", 32'(rq.resp_err), 0);
        chk("st_c4_rdata", 32'(rq.resp_rdata), 0);
        chk("st_mem5", 32'(memArr[5]), 32'hBEEF);
        rq.resp_ready = 1'b1;
        tick();
        chk("st_idle_ready", 32'(rq.req_ready), 1);
        chk("st_idle_valid", 32'(rq.resp_valid), 0);

        // Load back from 5.
        issue(1'b0, 16'h0005, 16'h0000);
        tick();
        chk("ld_c2_strobes", {30'd0, mb.mem_read, mb.mem_write}, 2);
        tick();
        tick();
        chk("ld_c4_valid", 32'(rq.resp_valid), 1);
        chk("ld_c4_rdata", 32'(rq.resp_rdata), 32'hBEEF);
        tick();

        // Out of range load.
        rdBefore = rdCycles;
        wrBefore = wrCycles;
        issue(1'b0, 16'h0100, 16'h0000);
        chk("oor_c1_valid", 32'(rq.resp_valid), 1);
        chk("oor_c1_err", 32'(rq.resp_err), 1);
        chk("oor_c1_rdata", 32'(rq.resp_rdata), 0);
        chk("oor_addr_kept", 32'(mb.mem_address), 32'h5);
        tick();
        chk("oor_idle", 32'(rq.req_ready), 1);
        tick();
        chk("oor_no_strobe", 32'(rdCycles - rdBefore + wrCycles - wrBefore), 0);

        // Max address error: no wrap-around.
        issue(1'b1, 16'hFFFF, 16'h1111);
        chk("oor_ffff_err", 32'(rq.resp_err), 1);
        tick();

        // Backpressure.
        memArr[7] = 16'h1234;
        rq.resp_ready = 1'b0;
        issue(1'b0, 16'h0007, 16'h0000);
        tick();
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rq.resp_valid !== 1'b1 || rq.resp_rdata !== 16'h1234 ||
                rq.req_ready !== 1'b0 || rq.resp_err !== 1'b0)
                bad++;
            tick();
        end
        chk("bp_hold", 32'(bad), 0);
        chk("bp_rdata", 32'(rq.resp_rdata), 32'h1234);
        rq.resp_ready = 1'b1;
        tick();
        chk("bp_release", {30'd0, rq.req_ready, rq.resp_valid}, 2);

        // Back-to-back stores with req_valid held.
        addrs[0] = 16'h00FF; datas[0] = 16'hA0A0;
        addrs[1] = 16'h0000; datas[1] = 16'hB1B1;
        addrs[2] = 16'h0001; datas[2] = 16'hC2C2;
        rq.req_valid = 1'b1;
        rq.req_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rq.req_addr  = addrs[k];
            rq.req_wdata = datas[k];
            n = 0;
            while (rq.req_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) chk("b2b_timeout", 0, 1);
            acc[k] = cyc;
            tick();
        end
        rq.req_valid = 1'b0;
        n = 0;
        while (rq.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("b2b_drain_timeout", 0, 1);
        chk("b2b_gap01", 32'(acc[1] - acc[0]), 5);
        chk("b2b_gap12", 32'(acc[2] - acc[1]), 5);
        chk("b2b_memff", 32'(memArr[255]), 32'hA0A0);
        chk("b2b_mem0", 32'(memArr[0]), 32'hB1B1);
        chk("b2b_mem1", 32'(memArr[1]), 32'hC2C2);

        // Back-to-back errors: 2-cycle spacing.
        rq.req_valid = 1'b1;
        rq.req_addr = 16'h0200;
        acc[0] = cyc;
        tick();
        n = 0;
        while (rq.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        acc[1] = cyc;
        tick();
        rq.req_valid = 1'b0;
        chk("err_gap", 32'(acc[1] - acc[0]), 2);
        tick();

        // Reset during store strobe.
        issue(1'b1, 16'h0009, 16'h5555);
        tick();
        chk("rm_c2_write", 32'(mb.mem_write), 1);
        #2 rst = 1'b1;
        #1;
        chk("rm_write_drop", 32'(mb.mem_write), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rm_ready", 32'(rq.req_ready), 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rq.resp_valid !== 1'b0) bad++;
            tick();
        end
        chk("rm_no_resp", 32'(bad), 0);
        chk("rm_mem9", 32'(memArr[9]), 0);

        chk("no_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
